// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: EX/D-stage handshake and HI/LO result bundle for muldiv_unit.
// The pipeline side drives through the master modport; the unit uses slave.
interface muldiv_unit_if;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 2;

  logic              startE;
  logic [OP_W-1:0]   opE;
  logic [DATA_W-1:0] srcaE;
  logic [DATA_W-1:0] srcbE;
  logic              mthiE;
  logic              mtloE;
  logic              mdaccessD;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
  logic              busy;
  logic              mdstallD;
  logic              done;

  modport master (
    output startE, opE, srcaE, srcbE, mthiE, mtloE, mdaccessD,
    input  hi, lo, busy, mdstallD, done
  );

  modport slave (
    input  startE, opE, srcaE, srcbE, mthiE, mtloE, mdaccessD,
    output hi, lo, busy, mdstallD, done
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 MULT/MULTU/DIV/DIVU with architectural HI/LO.
// Operations run on operand magnitudes for 32 cycles; a FIX cycle restores
// signs and writes HI/LO. Optional macro MULDIV_FAST_MUL_EN computes
// multiplies combinationally in a single cycle; divide is unaffected.
module muldiv_unit (
  input logic          clk,
  input logic          reset,
  muldiv_unit_if.slave mdBus
);
  localparam int unsigned W     = 32;
  localparam int unsigned W2    = 64;
  localparam int unsigned CNT_W = 5;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]       state,    stateNext;
  logic [CNT_W-1:0] cnt,      cntNext;
  logic             isDiv,    isDivNext;
  logic             negRes,   negResNext;
  logic             negRem,   negRemNext;
  logic             divZero,  divZeroNext;
  logic [W-1:0]     opM,      opMNext;
  logic [W-1:0]     accHi,    accHiNext;
  logic [W-1:0]     accLo,    accLoNext;
  logic [W-1:0]     hiReg,    hiNext;
  logic [W-1:0]     loReg,    loNext;
  logic             busyReg,  busyNext;
  logic             doneReg,  doneNext;

  // Operand magnitudes and sign flags for the incoming instruction
  logic         isSignedOp;
  logic         negA;
  logic         negB;
  logic [W-1:0] magA;
  logic [W-1:0] magB;
  logic         startIter;

  assign isSignedOp = ~mdBus.opE[0];
  assign negA       = isSignedOp & mdBus.srcaE[W-1];
  assign negB       = isSignedOp & mdBus.srcbE[W-1];
  assign magA       = negA ? W'(W'(0) - mdBus.srcaE) : mdBus.srcaE;
  assign magB       = negB ? W'(W'(0) - mdBus.srcbE) : mdBus.srcbE;

`ifdef MULDIV_FAST_MUL_EN
  // Single-cycle multiply: only divides take the iterative path
  logic          fastMul;
  logic [W2-1:0] fastProd;

  assign startIter = mdBus.startE & mdBus.opE[1];
  assign fastMul   = mdBus.startE & ~mdBus.opE[1];
  assign fastProd  = mdBus.opE[0]
                   ? W2'({{W{1'b0}}, mdBus.srcaE} * {{W{1'b0}}, mdBus.srcbE})
                   : W2'({{W{mdBus.srcaE[W-1]}}, mdBus.srcaE} *
                         {{W{mdBus.srcbE[W-1]}}, mdBus.srcbE});
`else
  assign startIter = mdBus.startE;
`endif

  // Shift-add multiply step: add multiplicand when multiplier LSB is set,
  // then shift the 65-bit {carry, accHi, accLo} right by one
  logic [W:0]   mulSum;
  logic [W-1:0] mulHi;
  logic [W-1:0] mulLo;

  assign mulSum = {1'b0, accHi} + {1'b0, opM};
  assign mulHi  = accLo[0] ? mulSum[W:1] : {1'b0, accHi[W-1:1]};
  assign mulLo  = accLo[0] ? {mulSum[0], accLo[W-1:1]} : {accHi[0], accLo[W-1:1]};

  // Restoring divide step: shift next dividend bit into the remainder and
  // keep the difference only when it does not borrow
  logic [W:0]   divShift;
  logic [W+1:0] divDiff;
  logic         divFits;
  logic [W-1:0] divHi;
  logic [W-1:0] divLo;

  assign divShift = {accHi, accLo[W-1]};
  assign divDiff  = {1'b0, divShift} - {2'b0, opM};
  assign divFits  = ~divDiff[W+1];
  assign divHi    = divFits ? divDiff[W-1:0] : divShift[W-1:0];
  assign divLo    = {accLo[W-2:0], divFits};

  // Sign-corrected results applied in FIX
  logic [W2-1:0] prodRaw;
  logic [W2-1:0] prodFix;
  logic [W-1:0]  quotFix;
  logic [W-1:0]  remFix;

  assign prodRaw = {accHi, accLo};
  assign prodFix = negRes ? W2'(W2'(0) - prodRaw) : prodRaw;
  assign quotFix = divZero ? {W{1'b1}} : (negRes ? W'(W'(0) - accLo) : accLo);
  assign remFix  = negRem ? W'(W'(0) - accHi) : accHi;

  // Next-state and datapath update logic
  always_comb begin
    stateNext   = state;
    cntNext     = cnt;
    isDivNext   = isDiv;
    negResNext  = negRes;
    negRemNext  = negRem;
    divZeroNext = divZero;
    opMNext     = opM;
    accHiNext   = accHi;
    accLoNext   = accLo;
    hiNext      = hiReg;
    loNext      = loReg;
    doneNext    = 1'b0;

    case (state)
      IDLE: begin
        if (startIter) begin
          stateNext   = RUN;
          cntNext     = CNT_W'(W - 1);
          isDivNext   = mdBus.opE[1];
          negResNext  = negA ^ negB;
          negRemNext  = negA;
          divZeroNext = mdBus.opE[1] & (mdBus.srcbE == W'(0));
          accHiNext   = W'(0);
          accLoNext   = mdBus.opE[1] ? magA : magB;
          opMNext     = mdBus.opE[1] ? magB : magA;
`ifdef MULDIV_FAST_MUL_EN
        end else if (fastMul) begin
          hiNext   = fastProd[W2-1:W];
          loNext   = fastProd[W-1:0];
          doneNext = 1'b1;
`endif
        end else begin
          if (mdBus.mthiE) hiNext = mdBus.srcaE;
          if (mdBus.mtloE) loNext = mdBus.srcaE;
        end
      end
      RUN: begin
        accHiNext = isDiv ? divHi : mulHi;
        accLoNext = isDiv ? divLo : mulLo;
        cntNext   = CNT_W'(cnt - CNT_W'(1));
        if (cnt == CNT_W'(0)) begin
          stateNext = FIX;
          cntNext   = CNT_W'(0);
        end
      end
      FIX: begin
        if (isDiv) begin
          hiNext = remFix;
          loNext = quotFix;
        end else begin
          hiNext = prodFix[W2-1:W];
          loNext = prodFix[W-1:0];
        end
        doneNext  = 1'b1;
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase

    busyNext = (stateNext != IDLE);
  end

  // State, datapath and architectural register update with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= CNT_W'(0);
      isDiv   <= 1'b0;
      negRes  <= 1'b0;
      negRem  <= 1'b0;
      divZero <= 1'b0;
      opM     <= W'(0);
      accHi   <= W'(0);
      accLo   <= W'(0);
      hiReg   <= W'(0);
      loReg   <= W'(0);
      busyReg <= 1'b0;
      doneReg <= 1'b0;
    end else begin
      state   <= stateNext;
      cnt     <= cntNext;
      isDiv   <= isDivNext;
      negRes  <= negResNext;
      negRem  <= negRemNext;
      divZero <= divZeroNext;
      opM     <= opMNext;
      accHi   <= accHiNext;
      accLo   <= accLoNext;
      hiReg   <= hiNext;
      loReg   <= loNext;
      busyReg <= busyNext;
      doneReg <= doneNext;
    end
  end

  assign mdBus.hi       = hiReg;
  assign mdBus.lo       = loReg;
  assign mdBus.busy     = busyReg;
  assign mdBus.done     = doneReg;
  // Stall request is combinational so a D-stage access is held off immediately
  assign mdBus.mdstallD = busyReg & mdBus.mdaccessD;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors for muldiv_unit with hand-computed results.
module tb_muldiv_unit;
  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT  = 0;
  localparam int MUL_BUSY = 0;
`else
  localparam int MUL_LAT  = 33;
  localparam int MUL_BUSY = 33;
`endif
  localparam int DIV_LAT  = 33;
  localparam int DIV_BUSY = 33;

  logic clk;
  logic reset;
  int   vecs;
  int   errs;

  muldiv_unit_if mdIf ();

  muldiv_unit dut (
    .clk   (clk),
    .reset (reset),
    .mdBus (mdIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one op from idle and observe 41 post-edge samples starting at the start edge
  task automatic runOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic acc, input logic mth,
                       output logic [31:0] h, output logic [31:0] l, output int lat,
                       output int busyN, output int stallN, output int doneN,
                       output logic [31:0] midH);
    mdIf.opE       = op;
    mdIf.srcaE     = a;
    mdIf.srcbE     = b;
    mdIf.mdaccessD = acc;
    mdIf.mthiE     = mth;
    mdIf.startE    = 1'b1;
    @(posedge clk); #1;
    mdIf.startE = 1'b0;
    mdIf.mthiE  = 1'b0;
    lat = -1; busyN = 0; stallN = 0; doneN = 0;
    h = 32'h0; l = 32'h0; midH = 32'h0;
    for (int i = 0; i <= 40; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      if (mdIf.busy) busyN++;
      if (mdIf.mdstallD) stallN++;
      if (i == 10) midH = mdIf.hi;
      if (mdIf.done) begin
        doneN++;
        if (lat < 0) begin
          lat = i;
          h = mdIf.hi;
          l = mdIf.lo;
        end
      end
    end
    mdIf.mdaccessD = 1'b0;
  endtask

  task automatic test_reset;
    vecs++; if (mdIf.hi !== 32'h0) begin errs++; $display("FAIL reset_hi: got %h expected %h", mdIf.hi, 32'h0); end
    vecs++; if (mdIf.lo !== 32'h0) begin errs++; $display("FAIL reset_lo: got %h expected %h", mdIf.lo, 32'h0); end
    vecs++; if (mdIf.busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b expected 0", mdIf.busy); end
    vecs++; if (mdIf.done !== 1'b0) begin errs++; $display("FAIL reset_done: got %b expected 0", mdIf.done); end
    vecs++; if (mdIf.mdstallD !== 1'b0) begin errs++; $display("FAIL reset_stall: got %b expected 0", mdIf.mdstallD); end
  endtask

  task automatic test_mul;
    logic [31:0] h, l, m;
    int lat, bn, sn, dn;
    runOp(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, h, l, lat, bn, sn, dn, m);
    vecs++; if (h !== 32'hFFFFFFFE) begin errs++; $display("FAIL multu_max_hi: got %h expected %h", h, 32'hFFFFFFFE); end
    vecs++; if (l !== 32'h00000001) begin errs++; $display("FAIL multu_max_lo: got %h expected %h", l, 32'h1); end
    vecs++; if (lat !== MUL_LAT) begin errs++; $display("FAIL multu_latency: got %0d expected %0d", lat, MUL_LAT); end
    vecs++; if (dn !== 1) begin errs++; $display("FAIL multu_done_count: got %0d expected 1", dn); end
    vecs++; if (bn !== MUL_BUSY) begin errs++; $display("FAIL multu_busy_cycles: got %0d expected %0d", bn, MUL_BUSY); end

    runOp(OP_MULT, 32'hFFFFFFFB, 32'hFFFFFFF9, 1'b0, 1'b0, h, l, lat, bn, sn, dn, m);
    vecs++; if (h !== 32'h0) begin errs++; $display("FAIL mult_negneg_hi: got %h expected %h", h, 32'h0); end
    vecs++; if (l !== 32'h23) begin errs++; $display("FAIL mult_negneg_lo: got %h expected %h", l, 32'h23); end

    runOp(OP_MULT, 32'h80000000, 32'h80000000, 1'b0, 1'b0, h, l, lat, bn, sn, dn, m);
    vecs++; if (h !== 32'h40000000) begin errs++; $display("FAIL mult_minmin_hi: got %h expected %h", h, 32'h40000000); end
    vecs++; if (l !== 32'h0) begin errs++; $display("FAIL mult_minmin_lo: got %h expected %h", l, 32'h0); end
  endtask

  task automatic test_div;
    logic [31:0] h, l, m;
    int lat, bn, sn, dn;
    runOp(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0, h, l, lat, bn, sn, dn, m);
    vecs++; if (l !== 32'hFFFFFFFD) begin errs++; $display("FAIL div_m7_2_lo: got %h expected %h", l, 32'hFFFFFFFD); end
    vecs++; if (h !== 32'hFFFFFFFF) begin errs++; $display("FAIL div_m7_2_hi: got %h expected %h", h, 32'hFFFFFFFF); end
    vecs++; if (bn !== DIV_BUSY) begin errs++; $display("FAIL div_busy_cycles: got %0d expected %0d", bn, DIV_BUSY); end
    vecs++; if (lat !== DIV_LAT) begin errs++; $display("FAIL div_latency: got %0d expected %0d", lat, DIV_LAT); end
    vecs++; if (m !== 32'h40000000) begin errs++; $display("FAIL div_hi_hold: got %h expected %h", m, 32'h40000000); end
    vecs++; if (dn !== 1) begin errs++; $display("FAIL div_done_count: got %0d expected 1", dn); end

    runOp(OP_DIV, 32'd7, 32'hFFFFFFFE, 1'b0, 1'b0, h, l, lat, bn, sn, dn, m);
    vecs++; if (l !== 32'hFFFFFFFD) begin errs++; $display("FAIL div_7_m2_lo: got %h expected %h", l, 32'hFFFFFFFD); end
    vecs++; if (h !== 32'h1) begin errs++; $display("FAIL div_7_m2_hi: got %h expected %h", h, 32'h1); end

    runOp(OP_DIVU, 32'hFFFFFFFF, 32'd16, 1'b0, 1'b0, h, l, lat, bn, sn, dn, m);
    vecs++; if (l !== 32'h0FFFFFFF) begin errs++; $display("FAIL divu_max_16_lo: got %h expected %h", l, 32'h0FFFFFFF); end
    vecs++; if (h !== 32'hF) begin errs++; $display("FAIL divu_max_16_hi: got %h expected %h", h, 32'hF); end
  endtask

  task automatic test_div_boundary;
    logic [31:0] h, l, m;
    int lat, bn, sn, dn;
    runOp(OP_DIVU, 32'd100, 32'd0, 1'b0, 1'b0, h, l, lat, bn, sn, dn, m);
    vecs++; if (l !== 32'hFFFFFFFF) begin errs++; $display("FAIL divu_by0_lo: got %h expected %h", l, 32'hFFFFFFFF); end
    vecs++; if (h !== 32'd100) begin errs++; $display("FAIL divu_by0_hi: got %h expected %h", h, 32'd100); end
    vecs++; if (lat !== DIV_LAT) begin errs++; $display("FAIL divu_by0_latency: got %0d expected %0d", lat, DIV_LAT); end

    runOp(OP_DIV, 32'hFFFFFFF8, 32'd0, 1'b0, 1'b0, h, l, lat, bn, sn, dn, m);
    vecs++; if (l !== 32'hFFFFFFFF) begin errs++; $display("FAIL div_neg_by0_lo: got %h expected %h", l, 32'hFFFFFFFF); end
    vecs++; if (h !== 32'hFFFFFFF8) begin errs++; $display("FAIL div_neg_by0_hi: got %h expected %h", h, 32'hFFFFFFF8); end

    runOp(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, h, l, lat, bn, sn, dn, m);
    vecs++; if (l !== 32'h80000000) begin errs++; $display("FAIL div_ovf_lo: got %h expected %h", l, 32'h80000000); end
    vecs++; if (h !== 32'h0) begin errs++; $display("FAIL div_ovf_hi: got %h expected %h", h, 32'h0); end
  endtask

  task automatic test_stall_and_moves;
    logic [31:0] h, l, m;
    int lat, bn, sn, dn;
    runOp(OP_DIVU, 32'd1000, 32'd7, 1'b1, 1'b0, h, l, lat, bn, sn, dn, m);
    vecs++; if (sn !== DIV_BUSY) begin errs++; $display("FAIL stall_with_access: got %0d expected %0d", sn, DIV_BUSY); end
    vecs++; if (l !== 32'd142 || h !== 32'd6) begin errs++; $display("FAIL divu_1000_7: got %h/%h expected %h/%h", h, l, 32'd6, 32'd142); end

    runOp(OP_DIVU, 32'd1000, 32'd7, 1'b0, 1'b0, h, l, lat, bn, sn, dn, m);
    vecs++; if (sn !== 0) begin errs++; $display("FAIL stall_without_access: got %0d expected 0", sn); end

    mdIf.srcaE = 32'h1234;
    mdIf.mthiE = 1'b1;
    @(posedge clk); #1;
    mdIf.mthiE = 1'b0;
    vecs++; if (mdIf.hi !== 32'h1234) begin errs++; $display("FAIL mthi_write: got %h expected %h", mdIf.hi, 32'h1234); end
    vecs++; if (mdIf.lo !== 32'd142) begin errs++; $display("FAIL mthi_lo_untouched: got %h expected %h", mdIf.lo, 32'd142); end

    mdIf.srcaE = 32'h5678;
    mdIf.mtloE = 1'b1;
    @(posedge clk); #1;
    mdIf.mtloE = 1'b0;
    vecs++; if (mdIf.lo !== 32'h5678) begin errs++; $display("FAIL mtlo_write: got %h expected %h", mdIf.lo, 32'h5678); end

    // startE together with mthiE: the move must be dropped
    runOp(OP_MULTU, 32'd2, 32'd3, 1'b0, 1'b1, h, l, lat, bn, sn, dn, m);
    vecs++; if (h !== 32'h0 || l !== 32'd6) begin errs++; $display("FAIL start_beats_mthi: got %h/%h expected %h/%h", h, l, 32'h0, 32'd6); end
`ifndef MULDIV_FAST_MUL_EN
    vecs++; if (m !== 32'h1234) begin errs++; $display("FAIL start_beats_mthi_mid: got %h expected %h", m, 32'h1234); end
`endif
  endtask

  task automatic test_reset_midop;
    logic [31:0] h, l, m;
    int lat, bn, sn, dn, lateDone;
    mdIf.opE    = OP_DIV;
    mdIf.srcaE  = 32'd1000;
    mdIf.srcbE  = 32'd7;
    mdIf.startE = 1'b1;
    @(posedge clk); #1;
    mdIf.startE = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    vecs++; if (mdIf.busy !== 1'b1) begin errs++; $display("FAIL midop_busy: got %b expected 1", mdIf.busy); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    vecs++; if (mdIf.hi !== 32'h0 || mdIf.lo !== 32'h0) begin errs++; $display("FAIL midop_reset_hilo: got %h/%h expected 0/0", mdIf.hi, mdIf.lo); end
    vecs++; if (mdIf.busy !== 1'b0) begin errs++; $display("FAIL midop_reset_busy: got %b expected 0", mdIf.busy); end
    lateDone = 0;
    for (int i = 0; i < 40; i++) begin
      if (mdIf.done || mdIf.busy) lateDone++;
      @(posedge clk); #1;
    end
    vecs++; if (lateDone !== 0) begin errs++; $display("FAIL midop_no_done: got %0d expected 0", lateDone); end

    runOp(OP_MULT, 32'd3, 32'hFFFFFFFE, 1'b0, 1'b0, h, l, lat, bn, sn, dn, m);
    vecs++; if (h !== 32'hFFFFFFFF) begin errs++; $display("FAIL post_reset_mult_hi: got %h expected %h", h, 32'hFFFFFFFF); end
    vecs++; if (l !== 32'hFFFFFFFA) begin errs++; $display("FAIL post_reset_mult_lo: got %h expected %h", l, 32'hFFFFFFFA); end
    vecs++; if (lat !== MUL_LAT) begin errs++; $display("FAIL post_reset_mult_latency: got %0d expected %0d", lat, MUL_LAT); end
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    reset          = 1'b1;
    mdIf.startE    = 1'b0;
    mdIf.opE       = 2'b00;
    mdIf.srcaE     = 32'h0;
    mdIf.srcbE     = 32'h0;
    mdIf.mthiE     = 1'b0;
    mdIf.mtloE     = 1'b0;
    mdIf.mdaccessD = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    reset = 1'b0;
    @(posedge clk); #1;
    test_mul;
    test_div;
    test_div_boundary;
    test_stall_and_moves;
    test_reset_midop;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
